// File: rtl/i2c_pkg.sv
// Shared types for the I2C byte sequencer: command encodings, FSM states,
// SCL quarter-phase names and byte-width constants.
package i2c_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = $clog2(BYTE_W);

    typedef enum logic [1:0] {
        OP_START = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_STOP  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } phase_e;

endpackage

// File: rtl/i2c_quarter_timer.sv
// SCL quarter-period timer: counts CLK_DIV clocks per quarter and steps the
// 2-bit phase Q0..Q3.
// Ports:
//   clock, reset_n : clock, synchronous active-low reset
//   enable         : count while high; count and phase cleared while low
//   pause          : hold the count (clock stretching)
//   tick_c         : last clock of the current quarter (combinational)
//   phase          : current quarter
module i2c_quarter_timer
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250,
    parameter int unsigned CNT_W   = 16
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   enable,
    input  logic   pause,
    output logic   tick_c,
    output phase_e phase
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_e           phase_q, phase_d;

    assign tick_c = enable && !pause && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign phase  = phase_q;

    // Next count / phase
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!enable) begin
            cnt_d   = '0;
            phase_d = Q0;
        end else if (tick_c) begin
            cnt_d   = '0;
            phase_d = phase_e'(2'(phase_q + 2'd1));
        end else if (!pause) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_byte_sequencer.sv
// Master-side I2C byte engine: executes one START / WRITE / READ / STOP
// command at a time and drives the open-drain SCL/SDA enables.
// Ports:
//   clock, reset_n           : clock, synchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake
//   cmd_op/cmd_data/cmd_ack_n: operation, write byte, ACK bit to send after READ
//   rsp_valid/rsp_data/rsp_nack : one-cycle response after WRITE/READ
//   busy, bus_held           : command executing / bus owned between START and STOP
//   scl_oe, sda_oe           : 1 pulls the line low
//   scl_in, sda_in           : pad readback
// Optional: define I2C_CLOCK_STRETCH_EN to hold the quarter timer while a
// slave keeps SCL low in Q2/Q3; otherwise scl_in is ignored.
module i2c_byte_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [BYTE_W-1:0] cmd_data,
    input  logic              cmd_ack_n,
    output logic              rsp_valid,
    output logic [BYTE_W-1:0] rsp_data,
    output logic              rsp_nack,
    output logic              busy,
    output logic              bus_held,
    output logic              scl_oe,
    output logic              sda_oe,
    input  logic              scl_in,
    input  logic              sda_in
);

    state_e                 state_q, state_d;
    logic [BYTE_W-1:0]      shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   is_read_q, is_read_d;
    logic                   ack_n_q, ack_n_d;
    logic                   bus_held_q, bus_held_d;
    logic                   busy_q, busy_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [BYTE_W-1:0]      rsp_data_q, rsp_data_d;
    logic                   rsp_nack_q, rsp_nack_d;
    logic                   scl_oe_q, scl_oe_d;
    logic                   sda_oe_q, sda_oe_d;
    phase_e                 phase, phase_n;
    logic                   tick_c, pause_c;

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding SCL low while we release it freezes the quarter count
    assign pause_c = ((phase == Q2) || (phase == Q3)) && !scl_oe_q && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign pause_c       = 1'b0;
`endif

    i2c_quarter_timer #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (state_q != ST_IDLE),
        .pause   (pause_c),
        .tick_c  (tick_c),
        .phase   (phase)
    );

    assign cmd_ready = (state_q == ST_IDLE) && reset_n;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_nack  = rsp_nack_q;
    assign busy      = busy_q;
    assign bus_held  = bus_held_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

    // Next state, datapath and line enables. The line enables are computed
    // from the next state/phase so the registered pins line up with the phase.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        is_read_d   = is_read_q;
        ack_n_d     = ack_n_q;
        bus_held_d  = bus_held_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_nack_d  = rsp_nack_q;
        scl_oe_d    = 1'b0;
        sda_oe_d    = 1'b0;
        phase_n     = (state_q == ST_IDLE) ? Q0
                    : (tick_c ? phase_e'(2'(phase + 2'd1)) : phase);

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    is_read_d = (cmd_op_e'(cmd_op) == OP_READ);
                    ack_n_d   = cmd_ack_n;
                    bit_cnt_d = '0;
                    unique case (cmd_op_e'(cmd_op))
                        OP_START: state_d = ST_START;
                        OP_WRITE: begin
                            state_d = ST_BIT;
                            shift_d = cmd_data;
                        end
                        OP_READ: begin
                            state_d = ST_BIT;
                            shift_d = '0;
                        end
                        OP_STOP:  state_d = ST_STOP;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_START: begin
                if (tick_c && (phase == Q3)) begin
                    state_d    = ST_IDLE;
                    bus_held_d = 1'b1;
                end
            end
            ST_BIT: begin
                if (tick_c && (phase == Q2) && is_read_q) begin
                    shift_d = {shift_q[BYTE_W-2:0], sda_in};
                end
                if (tick_c && (phase == Q3)) begin
                    if (!is_read_q) begin
                        shift_d = {shift_q[BYTE_W-2:0], 1'b0};
                    end
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (tick_c && (phase == Q2)) begin
                    rsp_nack_d = is_read_q ? 1'b0 : sda_in;
                end
                if (tick_c && (phase == Q3)) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    if (is_read_q) begin
                        rsp_data_d = shift_q;
                    end
                end
            end
            ST_STOP: begin
                // Without a held bus there is nothing to release
                if (!bus_held_q) begin
                    state_d = ST_IDLE;
                end else if (tick_c && (phase == Q3)) begin
                    state_d    = ST_IDLE;
                    bus_held_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_IDLE: begin
                scl_oe_d = bus_held_d;
                sda_oe_d = bus_held_d && sda_oe_q;
            end
            ST_START: begin
                unique case (phase_n)
                    Q0:      scl_oe_d = bus_held_d;
                    Q1:      ;
                    Q2:      sda_oe_d = 1'b1;
                    default: begin
                        scl_oe_d = 1'b1;
                        sda_oe_d = 1'b1;
                    end
                endcase
            end
            ST_BIT: begin
                scl_oe_d = (phase_n == Q0) || (phase_n == Q1);
                sda_oe_d = !is_read_d && !shift_d[BYTE_W-1];
            end
            ST_ACK: begin
                scl_oe_d = (phase_n == Q0) || (phase_n == Q1);
                sda_oe_d = is_read_d && !ack_n_d;
            end
            ST_STOP: begin
                if (bus_held_d) begin
                    scl_oe_d = (phase_n == Q0);
                    sda_oe_d = (phase_n == Q0) || (phase_n == Q1);
                end
            end
            default: ;
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            is_read_q   <= 1'b0;
            ack_n_q     <= 1'b0;
            bus_held_q  <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_nack_q  <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            is_read_q   <= is_read_d;
            ack_n_q     <= ack_n_d;
            bus_held_q  <= bus_held_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_nack_q  <= rsp_nack_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Bench for i2c_byte_sequencer: a per-cycle waveform model derived from the
// quarter-period timing rules, a negedge compare process, and a few literal
// expectations (latency, bit pattern, response values).
module tb_i2c_byte_sequencer;
    import i2c_pkg::*;

    localparam int K        = 4;
    localparam int BIT_CYC  = 4 * K;
    localparam int BYTE_CYC = 9 * BIT_CYC;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_ack_n;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       busy;
    logic       bus_held;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    logic slave_pull   = 1'b0;
    logic stretch_pull = 1'b0;

    // Open-drain pads: a line reads low when anyone pulls it
    assign sda_in = ~(sda_oe | slave_pull);
    assign scl_in = ~(scl_oe | stretch_pull);

    i2c_byte_sequencer #(.CLK_DIV(K), .CNT_W(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ack_n (cmd_ack_n),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .bus_held  (bus_held),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model state and per-cycle expectations
    logic       m_held = 1'b0;
    logic       m_sda  = 1'b0;
    logic [7:0] m_rsp_data = 8'h00;
    logic       m_rsp_nack = 1'b0;
    logic       e_scl = 1'b0, e_sda = 1'b0, e_busy = 1'b0, e_held = 1'b0, e_rv = 1'b0;
    logic       chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%h expected 0x%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("scl_oe",    8'(scl_oe),    8'(e_scl));
            check("sda_oe",    8'(sda_oe),    8'(e_sda));
            check("busy",      8'(busy),      8'(e_busy));
            check("bus_held",  8'(bus_held),  8'(e_held));
            check("cmd_ready", 8'(cmd_ready), 8'(!e_busy));
            check("rsp_valid", 8'(rsp_valid), 8'(e_rv));
            check("rsp_data",  rsp_data,      m_rsp_data);
            if (e_rv) check("rsp_nack", 8'(rsp_nack), 8'(m_rsp_nack));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle_exp();
        e_busy = 1'b0;
        e_rv   = 1'b0;
        e_held = m_held;
        e_scl  = m_held;
        e_sda  = m_held & m_sda;
    endtask

    // Expected lines for cycle j (1-based) after the handshake
    task automatic expect_cycle(input logic [1:0] op, input logic [7:0] data, input logic ack_n,
                                input logic [7:0] sbyte, input logic sack, input int j, input int n);
        int qi, b, q;
        qi = (j - 1) / K;
        b  = qi / 4;
        q  = qi % 4;
        e_busy     = 1'b1;
        e_held     = m_held;
        e_rv       = 1'b0;
        slave_pull = 1'b0;
        case (op)
            OP_START: begin
                e_scl = (q == 0) ? m_held : (q == 3);
                e_sda = (q >= 2);
            end
            OP_STOP: begin
                e_scl = (n > 1) && (q == 0);
                e_sda = (n > 1) && (q < 2);
            end
            default: begin
                e_scl = (q < 2);
                if (b < 8) begin
                    e_sda      = (op == OP_WRITE) ? ~data[3'(7 - b)] : 1'b0;
                    slave_pull = (op == OP_READ)  ? ~sbyte[3'(7 - b)] : 1'b0;
                end else begin
                    e_sda      = (op == OP_READ)  ? ~ack_n : 1'b0;
                    slave_pull = (op == OP_WRITE) ? sack   : 1'b0;
                end
            end
        endcase
    endtask

    task automatic finish_cmd(input logic [1:0] op, input logic ack_n,
                              input logic [7:0] sbyte, input logic sack);
        slave_pull = 1'b0;
        case (op)
            OP_START: begin m_held = 1'b1; m_sda = 1'b1; end
            OP_STOP:  begin m_held = 1'b0; m_sda = 1'b0; end
            OP_WRITE: begin m_sda = 1'b0; m_rsp_nack = ~sack; end
            default:  begin m_sda = ~ack_n; m_rsp_data = sbyte; m_rsp_nack = 1'b0; end
        endcase
        set_idle_exp();
        e_rv = (op == OP_WRITE) || (op == OP_READ);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic ack_n,
                           input logic [7:0] sbyte, input logic sack, input int abort_at,
                           output int lat, output logic [7:0] pat);
        int n;
        lat = 0;
        pat = 8'h00;
        set_idle_exp();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_ack_n = ack_n;
        step();
        cmd_valid = 1'b0;
        if (op == OP_START || (op == OP_STOP && m_held)) n = BIT_CYC;
        else if (op == OP_STOP) n = 1;
        else n = BYTE_CYC;
        for (int j = 1; j <= n + 1; j++) begin
            if (rsp_valid && lat == 0) lat = j;
            if (j <= n) begin
                expect_cycle(op, data, ack_n, sbyte, sack, j, n);
                if (op == OP_WRITE && j <= 8 * BIT_CYC && ((j - 1) / K) % 4 == 2)
                    pat[3'(7 - (j - 1) / BIT_CYC)] = ~sda_oe;
            end else begin
                finish_cmd(op, ack_n, sbyte, sack);
            end
            if (abort_at != 0 && j == abort_at) begin
                reset_n = 1'b0;
                step();
                reset_n    = 1'b1;
                slave_pull = 1'b0;
                m_held     = 1'b0;
                m_sda      = 1'b0;
                m_rsp_data = 8'h00;
                set_idle_exp();
                for (int i = 0; i < 40 * K; i++) step();
                return;
            end
            step();
        end
        set_idle_exp();
    endtask

    int         lat;
    logic [7:0] pat;

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        cmd_ack_n = 1'b1;
        repeat (3) step();
        check("reset_scl_oe",    8'(scl_oe),    8'h00);
        check("reset_sda_oe",    8'(sda_oe),    8'h00);
        check("reset_busy",      8'(busy),      8'h00);
        check("reset_bus_held",  8'(bus_held),  8'h00);
        check("reset_rsp_valid", 8'(rsp_valid), 8'h00);
        check("reset_rsp_data",  rsp_data,      8'h00);
        check("reset_rsp_nack",  8'(rsp_nack),  8'h00);
        check("reset_cmd_ready", 8'(cmd_ready), 8'h00);
        reset_n = 1'b1;
        #1;
        check("ready_after_reset", 8'(cmd_ready), 8'h01);
        set_idle_exp();
        chk_en = 1'b1;
        step();

        run_cmd(OP_START, 8'h00, 1'b1, 8'h00, 1'b0, 0, lat, pat);
        check("held_after_start", 8'(bus_held), 8'h01);

        run_cmd(OP_WRITE, 8'hA5, 1'b1, 8'h00, 1'b1, 0, lat, pat);
        check("write_latency", 8'(lat), 8'd145);
        check("write_pattern", pat, 8'hA5);
        check("write_ack",     8'(rsp_nack), 8'h00);

        run_cmd(OP_WRITE, 8'h3C, 1'b1, 8'h00, 1'b0, 0, lat, pat);
        check("write_nack", 8'(rsp_nack), 8'h01);

        run_cmd(OP_START, 8'h00, 1'b1, 8'h00, 1'b0, 0, lat, pat);
        run_cmd(OP_READ, 8'h00, 1'b1, 8'h5A, 1'b0, 0, lat, pat);
        check("read_data", rsp_data, 8'h5A);
        check("read_nack", 8'(rsp_nack), 8'h00);

        run_cmd(OP_READ, 8'h00, 1'b0, 8'hC3, 1'b0, 0, lat, pat);
        check("read2_data", rsp_data, 8'hC3);

        run_cmd(OP_STOP, 8'h00, 1'b1, 8'h00, 1'b0, 0, lat, pat);
        check("stop_held",   8'(bus_held), 8'h00);
        check("stop_scl_oe", 8'(scl_oe),   8'h00);
        check("stop_sda_oe", 8'(sda_oe),   8'h00);

        run_cmd(OP_STOP, 8'h00, 1'b1, 8'h00, 1'b0, 0, lat, pat);

        run_cmd(OP_START, 8'h00, 1'b1, 8'h00, 1'b0, 0, lat, pat);
        run_cmd(OP_WRITE, 8'hF0, 1'b1, 8'h00, 1'b1, 3 * BIT_CYC + 5, lat, pat);
        check("abort_held",     8'(bus_held), 8'h00);
        check("abort_no_rsp",   8'(lat),      8'h00);
        check("abort_rsp_data", rsp_data,     8'h00);

`ifdef I2C_CLOCK_STRETCH_EN
        run_cmd(OP_START, 8'h00, 1'b1, 8'h00, 1'b0, 0, lat, pat);
        chk_en    = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_data  = 8'h81;
        step();
        cmd_valid = 1'b0;
        lat       = 0;
        // Hold SCL low from the second clock of bit 2's Q2 for 20 clocks
        for (int j = 1; j <= 400 && lat == 0; j++) begin
            stretch_pull = (j >= 2 * BIT_CYC + 2 * K + 2) && (j < 2 * BIT_CYC + 2 * K + 22);
            if (rsp_valid) lat = j;
            step();
        end
        stretch_pull = 1'b0;
        check("stretch_latency", 8'(lat), 8'd165);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_byte_sequencer.md
Name: i2c_byte_sequencer

Overview:
Master-side I2C byte engine that sequences an internal 8-bit shift register and generates SCL/SDA timing for one bus operation at a time. The host issues START / WRITE / READ / STOP commands over a valid/ready handshake. The block returns received data and ACK status through a one-cycle response strobe. It sits between the controller's command logic and the open-drain pad drivers.

Parameters:
CLK_DIV, 250, system clocks per SCL quarter-period (legal range 2..65535); one SCL bit = 4*CLK_DIV clocks.
CNT_W, 16, width of the quarter-period counter; must hold CLK_DIV-1.

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 START, 01 WRITE, 10 READ, 11 STOP
cmd_data  in  8  byte to transmit (WRITE)
cmd_ack_n  in  1  ACK bit to drive after READ (0=ACK, 1=NACK)
rsp_valid  out  1  one-cycle pulse at end of WRITE/READ
rsp_data  out  8  received byte (READ); holds the last value otherwise
rsp_nack  out  1  sampled ACK slot (WRITE); 0 for READ
busy  out  1  high while any command executes
bus_held  out  1  high between START completion and STOP completion
scl_oe  out  1  1 = pull SCL low
sda_oe  out  1  1 = pull SDA low
scl_in  in  1  SCL pad readback
sda_in  in  1  SDA pad readback

Behaviour:
- Reset is synchronous, active-low, on clock.
- Reset values: scl_oe=0, sda_oe=0, busy=0, bus_held=0, rsp_valid=0, rsp_data=0, rsp_nack=0, state=IDLE, counters=0.
- Reset mid-operation aborts immediately and releases both lines; no response is issued.
- cmd_ready = (state==IDLE) && reset_n. A command is captured on the cycle of handshake. busy rises on the next cycle.
- Timing: each phase lasts exactly CLK_DIV clocks. Phases Q0..Q3 repeat per bit.
- States: IDLE, START, BIT, ACK, STOP.
- START (Q0..Q3): Q0 release SDA, keep SCL as is. Q1 release SCL. Q2 SDA low. Q3 SCL low. Then bus_held=1 and go to IDLE. The same sequence is used as a repeated START when bus_held=1.
- WRITE: load cmd_data into the shift register, then BIT x8, MSB first.
  - Per bit: Q0 SCL low and SDA driven from shift MSB (sda_oe = ~bit). Q1 SCL low. Q2,Q3 SCL released. Shift left at the end of Q3.
  - ACK slot: SDA released; sda_in sampled at the last clock of Q2 into rsp_nack.
- READ: SDA released for 8 bits. sda_in is shifted in (LSB entry) at the last clock of Q2. ACK slot drives sda_oe = ~cmd_ack_n (captured value). rsp_nack=0.
- Response: rsp_valid pulses for 1 clock, the clock after ACK Q3 ends. rsp_data is updated in the same cycle. Returning to IDLE happens in that cycle.
- Byte latency: handshake to rsp_valid = 36*CLK_DIV + 1 clocks.
- STOP with bus_held=1: Q0 SCL low, SDA low. Q1 SCL released. Q2,Q3 SDA released. Then bus_held=0.
- STOP with bus_held=0: no bus activity; returns to IDLE the cycle after acceptance.
- WRITE/READ with bus_held=0: executed anyway; the host owns protocol correctness.
- SCL stays low (scl_oe=1) in IDLE while bus_held=1. Both lines are released in IDLE while bus_held=0.
- START and STOP generate no rsp_valid.

Optional Feature:
I2C_CLOCK_STRETCH_EN
- Defined: in Q2/Q3 of any state, if scl_oe=0 and scl_in=0, the quarter counter holds; it resumes the cycle scl_in reads 1.
- Undefined: scl_in is ignored; the port remains present and unused.

Decomposition:
- Package i2c_pkg: cmd_op encodings, state enum, phase enum (Q0..Q3), byte width constant (8).
- Sub-module i2c_quarter_timer:
  - Function: CNT_W counter producing a one-clock tick every CLK_DIV clocks.
  - Inputs: enable (clears the count when low) and pause (stretch hold).
  - Output: 2-bit phase.

Test Plan:
- CLK_DIV=4; reset; START -> SDA falls while SCL high (Q2), SCL low after 16 clocks; bus_held=1; no rsp_valid.
- WRITE 0xA5, slave pulls SDA low in ACK slot -> SDA bit pattern 1,0,1,0,0,1,0,1; rsp_valid at handshake+145 clocks; rsp_nack=0.
- WRITE 0x3C with SDA floating high in ACK slot -> rsp_nack=1.
- READ, slave drives 0x5A, cmd_ack_n=1 -> rsp_data=0x5A, rsp_nack=0, SDA released in ACK slot; READ with cmd_ack_n=0 -> sda_oe=1 during ACK slot.
- STOP after byte -> SDA rises while SCL high, bus_held=0, both oe=0. STOP while not held -> busy for 1 clock, oe unchanged.
- Assert reset_n=0 mid-WRITE (bit 3) -> next clock scl_oe=sda_oe=0, busy=0, no rsp_valid. With I2C_CLOCK_STRETCH_EN, hold scl_in=0 for 20 clocks in Q2 -> rsp_valid delayed by exactly 20 clocks.
